// File: rtl/avl_shim_elastic.sv
// Elastic FWFT beat FIFO between a NoC depacketizer with ready latency and a same-cycle-ready sink.
// Backpressure is registered; beats that arrive with the FIFO full and no pop are dropped and flagged.
module avl_shim_elastic #(
  parameter int AVL_DATA_WIDTH = 512,
  parameter int WIDTH_PKT      = AVL_DATA_WIDTH + 1 + 1 + 32,
  parameter int NUM_LANES      = 4,
  parameter int DEPTH          = 8,
  parameter int READY_LATENCY  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH_PKT-1:0]       noc_data_in,
  input  logic [NUM_LANES-1:0]       noc_valid_in,
  input  logic [NUM_LANES-1:0]       noc_sop_in,
  input  logic [NUM_LANES-1:0]       noc_eop_in,
  output logic                       noc_ready_out,
  output logic [WIDTH_PKT-1:0]       noc_data_out,
  output logic [NUM_LANES-1:0]       noc_valid_out,
  output logic [NUM_LANES-1:0]       noc_sop_out,
  output logic [NUM_LANES-1:0]       noc_eop_out,
  input  logic                       noc_ready_in,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       overflow_err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NL = NUM_LANES;
  localparam int EW = WIDTH_PKT + 3 * NL;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] THRESH = CW'(DEPTH - READY_LATENCY - 1);
  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);

  generate
    if ((READY_LATENCY < 0) || (DEPTH < READY_LATENCY + 1)) begin : g_bad_cfg
      $error("avl_shim_elastic: DEPTH must be at least READY_LATENCY+1");
    end
  endgenerate

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ready_q, ready_d;
  logic          ovf_q, ovf_d;
  logic          push, pop, push_ok;
  logic [EW-1:0] head;

  always_comb begin
    push     = |noc_valid_in;
    pop      = (count_q != '0) && noc_ready_in;
    // A full FIFO can still take a beat when the head leaves in the same cycle.
    push_ok  = push && ((count_q != FULL) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d   = ovf_q | (push & ~push_ok);
    // Leave READY_LATENCY+1 free slots for beats already in flight.
    ready_d = (count_d <= THRESH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= {noc_data_in, noc_valid_in, noc_sop_in, noc_eop_in};
  end

  always_comb begin
    head          = mem_q[rd_ptr_q];
    noc_data_out  = head[EW-1 -: WIDTH_PKT];
    noc_valid_out = (count_q != '0) ? head[3*NL-1 -: NL] : '0;
    noc_sop_out   = head[2*NL-1 -: NL];
    noc_eop_out   = head[NL-1:0];
  end

  assign noc_ready_out = ready_q;
  assign fill_level    = count_q;
  assign overflow_err  = ovf_q;

endmodule

// File: tb/tb_avl_shim_elastic.sv
// Directed bench for avl_shim_elastic: expected beats queued at issue, compared by a monitor on pop.
module tb_avl_shim_elastic;

  localparam int W  = 512 + 1 + 1 + 32;
  localparam int N  = 4;
  localparam int CW = 4;

  typedef struct {
    logic [W-1:0] d;
    logic [N-1:0] v;
    logic [N-1:0] s;
    logic [N-1:0] e;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  data_in;
  logic [N-1:0]  valid_in, sop_in, eop_in;
  logic          ready_out;
  logic [W-1:0]  data_out;
  logic [N-1:0]  valid_out, sop_out, eop_out;
  logic          ready_in;
  logic [CW-1:0] fill_level;
  logic          overflow_err;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];

  avl_shim_elastic dut (
    .clk(clk), .rst(rst),
    .noc_data_in(data_in), .noc_valid_in(valid_in), .noc_sop_in(sop_in), .noc_eop_in(eop_in),
    .noc_ready_out(ready_out),
    .noc_data_out(data_out), .noc_valid_out(valid_out), .noc_sop_out(sop_out), .noc_eop_out(eop_out),
    .noc_ready_in(ready_in), .fill_level(fill_level), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic [N-1:0] v, input logic [N-1:0] s,
                       input logic [N-1:0] e, input bit expect_out);
    beat_t b;
    data_in  = W'(d);
    valid_in = v;
    sop_in   = s;
    eop_in   = e;
    if (expect_out) begin
      b.d = W'(d); b.v = v; b.s = s; b.e = e;
      exp_q.push_back(b);
    end
  endtask

  task automatic idle_in();
    valid_in = '0; sop_in = '0; eop_in = '0; data_in = '0;
  endtask

  // Monitor: every beat the sink takes must be the oldest outstanding expected beat.
  always @(negedge clk) begin
    if (!rst && ready_in && (valid_out != '0)) begin
      beat_t b;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got data %0h with no beat expected", data_out);
      end else begin
        b = exp_q.pop_front();
        if (data_out !== b.d || valid_out !== b.v || sop_out !== b.s || eop_out !== b.e) begin
          errors++;
          $display("FAIL beat_order: got d=%0h v=%b s=%b e=%b expected d=%0h v=%b s=%b e=%b",
                   data_out, valid_out, sop_out, eop_out, b.d, b.v, b.s, b.e);
        end
      end
    end
  end

  initial begin
    int   sent;
    logic rh [12];
    logic allowed;

    rst = 1'b1; ready_in = 1'b0; idle_in();

    // Reset and idle
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_fill", 64'(fill_level), 64'd0);
    chk("rst_ovf", 64'(overflow_err), 64'd0);
    chk("rst_ready_first", 64'(ready_out), 64'd0);
    tick();
    chk("rst_ready_second", 64'(ready_out), 64'd1);

    // Streaming: occupancy holds at 1 because each beat leaves the cycle after it arrives
    ready_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(i, 4'b0001, (i == 0) ? 4'b0001 : 4'b0000, (i == 19) ? 4'b0001 : 4'b0000, 1'b1);
      tick();
      chk("stream_fill", 64'(fill_level), 64'd1);
    end
    idle_in();
    tick();
    chk("stream_drained", 64'(fill_level), 64'd0);
    chk("stream_ovf", 64'(overflow_err), 64'd0);

    // Backpressure; upstream sends in cycle a only if ready was 1 in cycle a-2
    ready_in = 1'b0;
    sent = 0;
    for (int a = 0; a < 12; a++) begin
      rh[a]   = ready_out;
      allowed = (a < 2) ? 1'b1 : rh[a-2];
      if (allowed) begin
        drive(100 + sent, 4'b0011, (sent == 0) ? 4'b0011 : 4'b0000, 4'b0000, 1'b1);
        sent++;
      end else begin
        idle_in();
      end
      tick();
    end
    idle_in();
    chk("bp_sent", 64'(sent), 64'd8);
    chk("bp_fill", 64'(fill_level), 64'd8);
    chk("bp_ovf", 64'(overflow_err), 64'd0);
    chk("bp_ready_low", 64'(ready_out), 64'd0);
    // count equalled a at cycle a for a<=8, so ready tracks count<=5
    for (int a = 0; a < 9; a++) chk("bp_ready_hist", 64'(rh[a]), (a <= 5) ? 64'd1 : 64'd0);

    // Full with simultaneous push and pop
    ready_in = 1'b1;
    drive(200, 4'b1000, 4'b1000, 4'b1000, 1'b1);
    tick();
    chk("full_pp_fill", 64'(fill_level), 64'd8);
    chk("full_pp_ovf", 64'(overflow_err), 64'd0);

    // Overflow: full, no pop, forced push is dropped
    ready_in = 1'b0;
    drive(300, 4'b0100, 4'b0000, 4'b0000, 1'b0);
    tick();
    idle_in();
    chk("ovf_set", 64'(overflow_err), 64'd1);
    chk("ovf_fill", 64'(fill_level), 64'd8);
    repeat (3) tick();
    chk("ovf_sticky", 64'(overflow_err), 64'd1);

    // Drain one per cycle, in order
    ready_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("drain_fill", 64'(fill_level), 64'(8 - k));
    end
    chk("drain_ovf_held", 64'(overflow_err), 64'd1);

    // Reset mid-stream discards stored beats
    ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(400 + i, 4'b0001, 4'b0000, 4'b0000, 1'b0);
      tick();
    end
    idle_in();
    chk("mid_fill5", 64'(fill_level), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_fill", 64'(fill_level), 64'd0);
    chk("mid_rst_valid", 64'(valid_out), 64'd0);
    chk("mid_rst_ovf", 64'(overflow_err), 64'd0);
    drive(500, 4'b0001, 4'b0001, 4'b0001, 1'b1);
    tick();
    idle_in();
    chk("fresh_data", data_out[63:0], 64'd500);
    chk("fresh_valid", 64'(valid_out), 64'd1);
    ready_in = 1'b1;
    tick();
    chk("fresh_drained", 64'(fill_level), 64'd0);
    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/avl_shim_elastic.md
Name: avl_shim_elastic

Overview:
- Parametrised elastic shim between a NoC depacketizer output (ready/valid, configurable ready latency) and an Avalon-style sink that uses same-cycle waitrequest/ready.
- Holds a DEPTH-entry first-word-fall-through FIFO of beats, so the NoC can keep sending for READY_LATENCY cycles after backpressure without losing data.
- Generalises the single-register skid to arbitrary lane count, depth and ready latency, and adds occupancy and overflow reporting.

Parameters:
AVL_DATA_WIDTH, 512, Avalon payload width
WIDTH_PKT, AVL_DATA_WIDTH+1+1+32, beat payload width after flit headers are stripped
NUM_LANES, 4, width of the valid/sop/eop vectors
DEPTH, 8, FIFO entries; legal iff DEPTH >= READY_LATENCY+1 (elaboration error otherwise); full throughput needs DEPTH >= 2*READY_LATENCY+2
READY_LATENCY, 2, cycles from noc_ready_out sample to the last beat upstream may still send (0..DEPTH-1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
noc_data_in  in  WIDTH_PKT  beat payload from NoC
noc_valid_in  in  NUM_LANES  per-lane valid; beat present iff any bit set
noc_sop_in  in  NUM_LANES  start-of-packet per lane
noc_eop_in  in  NUM_LANES  end-of-packet per lane
noc_ready_out  out  1  registered backpressure to NoC
noc_data_out  out  WIDTH_PKT  head-of-FIFO payload
noc_valid_out  out  NUM_LANES  head valid vector; all-zero when empty
noc_sop_out  out  NUM_LANES  head sop vector
noc_eop_out  out  NUM_LANES  head eop vector
noc_ready_in  in  1  sink ready (inverse of waitrequest), same-cycle
fill_level  out  $clog2(DEPTH+1)  current occupancy (registered count)
overflow_err  out  1  sticky: a beat was dropped

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: count=0, read/write pointers=0, noc_ready_out=0, overflow_err=0, fill_level=0, noc_valid_out=0. Storage contents are don't-care.
- Reset mid-operation: all stored beats are discarded with no drain.
- Push condition: |noc_valid_in. The entry stores {data, valid, sop, eop} unmodified.
- Push acceptance:
  - accepted if count<DEPTH, or if count==DEPTH and a pop occurs in the same cycle;
  - otherwise the beat is dropped and overflow_err is set to 1 until rst.
- Pop condition: count!=0 && noc_ready_in.
- Output side: noc_*_out are driven from the head entry whenever count!=0, and noc_valid_out=0 otherwise. sop/eop/data are don't-care when empty.
- No bypass: a beat pushed in cycle c is first visible on the outputs in cycle c+1. Minimum latency is 1 cycle.
- Count update: count_next = count + push_accepted - pop. Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of 2.
- noc_ready_out is registered: its value in cycle c+1 equals (count_next(c) <= DEPTH-READY_LATENCY-1).
  - Equivalently, ready in cycle c iff count(c) <= DEPTH-READY_LATENCY-1.
  - The first ready=1 appears in the second cycle after rst deasserts.
- Flow-control guarantee: if upstream only sends in cycle a when noc_ready_out was 1 in cycle a-READY_LATENCY, no beat is ever dropped and overflow_err stays 0. Any drop indicates an upstream protocol violation.
- Packet framing is not checked; sop/eop pass through unchanged. Order is strictly FIFO.
- fill_level equals count after the clock edge.

Test Plan:
- Reset and idle: assert rst 3 cycles, release -> noc_valid_out=0, fill_level=0, overflow_err=0; noc_ready_out=0 in the first cycle after release, 1 from the second.
- Streaming: noc_ready_in=1, 20 consecutive beats with data=i, valid=4'b0001 -> outputs identical beats, each 1 cycle after input, fill_level never exceeds 1, no drops.
- Backpressure with latency (DEPTH=8, RL=2): noc_ready_in=0, upstream obeys RL -> noc_ready_out falls once count reaches 6, last accepted beat brings fill_level to 8, no drop; release noc_ready_in -> 8 beats drain in order, 1 per cycle.
- Full with simultaneous push and pop: count=8, noc_ready_in=1, push beat X -> X accepted, fill_level stays 8, overflow_err=0.
- Overflow: count=8, noc_ready_in=0, force a push -> beat dropped, overflow_err=1 and held; FIFO contents unchanged; the flag clears only on rst.
- Reset mid-stream: fill_level=5, assert rst for 1 cycle -> fill_level=0, noc_valid_out=0 next cycle; a fresh beat afterwards emerges with its own data, not stale data.
